// File: rtl/classify_ctrl.sv
// Sequencer for the 10-class argmax comparator: buffers one frame of scores,
// waits out the comparator pipeline, then hands off the winning class.
module classify_ctrl #(
    parameter int unsigned SCORE_W     = 26,
    parameter int unsigned CMP_LATENCY = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   score_valid,
    output logic                   score_ready,
    input  logic [SCORE_W-1:0]     score_data,
    input  logic                   score_last,
    output logic [10*SCORE_W-1:0]  cmp_final,
    input  logic [3:0]             cmp_image_number,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [3:0]             result_class,
    output logic                   frame_err,
    output logic [CNT_W-1:0]       frame_count
);

    localparam int unsigned N_CLASS = 10;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned WC_W    = (CMP_LATENCY < 1) ? 1 : $clog2(CMP_LATENCY + 1);

    typedef enum logic [1:0] {S_ACCEPT, S_WAIT, S_DONE} state_e;

    state_e                             state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [WC_W-1:0]                    wait_cnt_q, wait_cnt_d;
    logic [N_CLASS-1:0][SCORE_W-1:0]    bank_q, bank_d;
    logic                               result_valid_q, result_valid_d;
    logic [3:0]                         result_class_q, result_class_d;
    logic                               frame_err_q, frame_err_d;
    logic [CNT_W-1:0]                   frame_count_q, frame_count_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_ACCEPT;
            idx_q          <= '0;
            wait_cnt_q     <= '0;
            bank_q         <= '0;
            result_valid_q <= 1'b0;
            result_class_q <= '0;
            frame_err_q    <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            wait_cnt_q     <= wait_cnt_d;
            bank_q         <= bank_d;
            result_valid_q <= result_valid_d;
            result_class_q <= result_class_d;
            frame_err_q    <= frame_err_d;
            frame_count_q  <= frame_count_d;
        end
    end

    // Next-state logic; the bank is only writable while accepting beats
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        wait_cnt_d     = wait_cnt_q;
        bank_d         = bank_q;
        result_valid_d = result_valid_q;
        result_class_d = result_class_q;
        frame_err_d    = 1'b0;
        frame_count_d  = frame_count_q;

        case (state_q)
            S_ACCEPT: begin
                if (score_valid) begin
                    for (int k = 0; k < int'(N_CLASS); k++) begin
                        if (idx_q == IDX_W'(k)) bank_d[k] = score_data;
                    end
                    if (idx_q == IDX_W'(N_CLASS - 1)) begin
                        idx_d = '0;
                        if (score_last) begin
                            wait_cnt_d = WC_W'(CMP_LATENCY);
                            state_d    = S_WAIT;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else if (score_last) begin
                        idx_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == '0) begin
                    result_class_d = cmp_image_number;
                    result_valid_d = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - WC_W'(1);
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    frame_count_d  = frame_count_q + CNT_W'(1);
                    state_d        = S_ACCEPT;
                end
            end
            default: state_d = S_ACCEPT;
        endcase
    end

    // Outputs: only score_ready is decoded from state, the rest come from flops
    always_comb begin
        score_ready = (state_q == S_ACCEPT);
    end

    assign cmp_final    = bank_q;
    assign result_valid = result_valid_q;
    assign result_class = result_class_q;
    assign frame_err    = frame_err_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_classify_ctrl.sv
// Directed bench for classify_ctrl with a 4-stage argmax comparator model.
module tb_classify_ctrl;

    localparam int unsigned SCORE_W = 26;
    localparam int unsigned CNT_W   = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   score_valid = 1'b0;
    logic                   score_ready;
    logic [SCORE_W-1:0]     score_data = '0;
    logic                   score_last = 1'b0;
    logic [10*SCORE_W-1:0]  cmp_final;
    logic [3:0]             cmp_image_number;
    logic                   result_valid;
    logic                   result_ready = 1'b0;
    logic [3:0]             result_class;
    logic                   frame_err;
    logic [CNT_W-1:0]       frame_count;

    logic                   score_ready_w;
    logic [10*SCORE_W-1:0]  cmp_final_w;
    logic                   result_valid_w;
    logic [3:0]             result_class_w;
    logic                   frame_err_w;
    logic [1:0]             frame_count_w;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    classify_ctrl #(.SCORE_W(SCORE_W), .CMP_LATENCY(4), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .score_valid(score_valid), .score_ready(score_ready),
        .score_data(score_data), .score_last(score_last), .cmp_final(cmp_final),
        .cmp_image_number(cmp_image_number), .result_valid(result_valid),
        .result_ready(result_ready), .result_class(result_class),
        .frame_err(frame_err), .frame_count(frame_count)
    );

    // Narrow-counter instance in lockstep to exercise counter wrap
    classify_ctrl #(.SCORE_W(SCORE_W), .CMP_LATENCY(4), .CNT_W(2)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .score_valid(score_valid), .score_ready(score_ready_w),
        .score_data(score_data), .score_last(score_last), .cmp_final(cmp_final_w),
        .cmp_image_number(cmp_image_number), .result_valid(result_valid_w),
        .result_ready(result_ready), .result_class(result_class_w),
        .frame_err(frame_err_w), .frame_count(frame_count_w)
    );

    // Comparator model: strict greater-than scanning from class 9 down, 4 pipeline stages
    function automatic logic [3:0] argmax(input logic [9:0][SCORE_W-1:0] s);
        int best = 9;
        for (int k = 8; k >= 0; k--) begin
            if ($signed(s[k]) > $signed(s[best])) best = k;
        end
        return 4'(best);
    endfunction

    logic [3:0] cmp_pipe [4];
    always @(posedge clk) begin
        cmp_pipe[0] <= argmax(cmp_final);
        for (int i = 1; i < 4; i++) cmp_pipe[i] <= cmp_pipe[i-1];
    end
    assign cmp_image_number = cmp_pipe[3];

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [SCORE_W-1:0] d, input logic last);
        int guard = 0;
        logic ok;
        score_valid = 1'b1;
        score_data  = d;
        score_last  = last;
        do begin
            ok = score_ready;
            cycle();
            guard++;
        end while (!ok && guard < 50);
        score_valid = 1'b0;
        score_last  = 1'b0;
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL beat_accept: score_ready stayed 0, required 1");
        end
    endtask

    task automatic send_frame(input logic [9:0][SCORE_W-1:0] s, input int gap_max);
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(0, gap_max)) cycle();
            send_beat(s[k], k == 9);
        end
    endtask

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!result_valid && cyc < 50) begin
            cycle();
            cyc++;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) cycle();
        n_cmp++; if (score_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", score_ready); end
        n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", result_valid); end
        n_cmp++; if (result_class !== 4'd0) begin n_fail++; $display("FAIL rst_class: got %0d want 0", result_class); end
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", frame_err); end
        n_cmp++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", frame_count); end
        n_cmp++; if (cmp_final !== '0) begin n_fail++; $display("FAIL rst_bank: got %h want 0", cmp_final); end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_ascending();
        logic [9:0][SCORE_W-1:0] s;
        int cyc;
        for (int k = 0; k < 10; k++) s[k] = SCORE_W'(k * 100);
        send_frame(s, 0);
        n_cmp++; if (cmp_final !== s) begin n_fail++; $display("FAIL asc_bank: got %h want %h", cmp_final, s); end
        n_cmp++; if (score_ready !== 1'b0) begin n_fail++; $display("FAIL asc_ready_wait: got %b want 0", score_ready); end
        wait_result(cyc);
        n_cmp++; if (cyc !== 5) begin n_fail++; $display("FAIL asc_latency: got %0d want 5", cyc); end
        n_cmp++; if (result_class !== 4'd9) begin n_fail++; $display("FAIL asc_class: got %0d want 9", result_class); end
        n_cmp++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL asc_count_pre: got %0d want 0", frame_count); end
        result_ready = 1'b1;
        cycle();
        result_ready = 1'b0;
        exp_count++;
        n_cmp++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL asc_count: got %0d want 1", frame_count); end
        n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL asc_rvalid_drop: got %b want 0", result_valid); end
        n_cmp++; if (score_ready !== 1'b1) begin n_fail++; $display("FAIL asc_ready_back: got %b want 1", score_ready); end
    endtask

    task automatic test_hold();
        logic [9:0][SCORE_W-1:0] s;
        int cyc;
        for (int k = 0; k < 10; k++) s[k] = SCORE_W'(-5);
        s[3] = 26'h1FFFFFF;
        send_frame(s, 0);
        wait_result(cyc);
        score_valid = 1'b1;
        score_data  = 26'h2AAAAAA;
        for (int c = 0; c < 7; c++) begin
            n_cmp++; if (result_valid !== 1'b1 || result_class !== 4'd3) begin
                n_fail++; $display("FAIL hold_result c%0d: got v=%b cls=%0d want v=1 cls=3", c, result_valid, result_class); end
            n_cmp++; if (score_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready c%0d: got %b want 0", c, score_ready); end
            n_cmp++; if (frame_count !== 16'(exp_count)) begin n_fail++; $display("FAIL hold_count c%0d: got %0d want %0d", c, frame_count, exp_count); end
            cycle();
        end
        n_cmp++; if (cmp_final !== s) begin n_fail++; $display("FAIL hold_bank: got %h want %h", cmp_final, s); end
        score_valid = 1'b0;
        result_ready = 1'b1;
        cycle();
        result_ready = 1'b0;
        exp_count++;
        n_cmp++; if (frame_count !== 16'(exp_count)) begin n_fail++; $display("FAIL hold_count_post: got %0d want %0d", frame_count, exp_count); end
    endtask

    task automatic test_ties();
        logic [9:0][SCORE_W-1:0] s;
        int cyc;
        s = '0;
        send_frame(s, 0);
        wait_result(cyc);
        n_cmp++; if (result_valid !== 1'b1 || result_class !== 4'd9) begin
            n_fail++; $display("FAIL tie_class: got v=%b cls=%0d want v=1 cls=9", result_valid, result_class); end
        result_ready = 1'b1;
        cycle();
        result_ready = 1'b0;
        exp_count++;
    endtask

    task automatic test_early_last();
        logic [9:0][SCORE_W-1:0] s;
        logic seen;
        int cyc;
        for (int k = 0; k < 4; k++) send_beat(SCORE_W'(k + 1), 1'b0);
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL early_err_pre: got %b want 0", frame_err); end
        send_beat(SCORE_W'(5), 1'b1);
        n_cmp++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL early_err: got %b want 1", frame_err); end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            seen = seen | result_valid;
            if (c == 0) begin
                n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL early_err_pulse: got %b want 0", frame_err); end
            end
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL early_no_result: got %b want 0", seen); end
        for (int k = 0; k < 10; k++) s[k] = SCORE_W'(k);
        s[6] = SCORE_W'(1000);
        send_frame(s, 0);
        wait_result(cyc);
        n_cmp++; if (result_valid !== 1'b1 || result_class !== 4'd6) begin
            n_fail++; $display("FAIL early_recover: got v=%b cls=%0d want v=1 cls=6", result_valid, result_class); end
        result_ready = 1'b1;
        cycle();
        result_ready = 1'b0;
        exp_count++;
        n_cmp++; if (frame_count !== 16'(exp_count)) begin n_fail++; $display("FAIL early_count: got %0d want %0d", frame_count, exp_count); end
    endtask

    task automatic test_no_last();
        logic seen;
        for (int k = 0; k < 9; k++) send_beat(SCORE_W'(k * 3), 1'b0);
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL nolast_err_pre: got %b want 0", frame_err); end
        send_beat(SCORE_W'(27), 1'b0);
        n_cmp++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL nolast_err: got %b want 1", frame_err); end
        seen = 1'b0;
        repeat (8) begin
            cycle();
            seen = seen | result_valid | ~score_ready;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL nolast_no_result: got %b want 0", seen); end
    endtask

    task automatic test_reset_in_wait();
        logic [9:0][SCORE_W-1:0] s;
        int cyc;
        for (int k = 0; k < 10; k++) s[k] = SCORE_W'(-(k + 1));
        s[2] = SCORE_W'(77);
        send_frame(s, 0);
        repeat (2) cycle();
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (score_ready !== 1'b1 || result_valid !== 1'b0 || result_class !== 4'd0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL arst_ctrl: got rdy=%b v=%b cls=%0d err=%b want 1 0 0 0", score_ready, result_valid, result_class, frame_err); end
        n_cmp++; if (frame_count !== 16'd0 || cmp_final !== '0) begin
            n_fail++; $display("FAIL arst_state: got cnt=%0d bank=%h want 0 0", frame_count, cmp_final); end
        cycle();
        rst_n = 1'b1;
        exp_count = 0;
        cycle();
        send_frame(s, 0);
        wait_result(cyc);
        n_cmp++; if (cyc !== 5 || result_class !== 4'd2) begin
            n_fail++; $display("FAIL arst_next: got lat=%0d cls=%0d want 5 2", cyc, result_class); end
        result_ready = 1'b1;
        cycle();
        result_ready = 1'b0;
        exp_count++;
        n_cmp++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL arst_count: got %0d want 1", frame_count); end
    endtask

    task automatic test_back_to_back();
        logic [9:0][SCORE_W-1:0] s;
        int cyc;
        int m;
        result_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            m = (f * 7 + 3) % 10;
            for (int k = 0; k < 10; k++) s[k] = SCORE_W'(int'($urandom_range(0, 1000)) - 500);
            s[m] = SCORE_W'(5000);
            send_frame(s, 2);
            wait_result(cyc);
            n_cmp++; if (result_valid !== 1'b1 || result_class !== 4'(m)) begin
                n_fail++; $display("FAIL b2b_class f%0d: got v=%b cls=%0d want v=1 cls=%0d", f, result_valid, result_class, m); end
            cycle();
            exp_count++;
            n_cmp++; if (frame_count !== 16'(exp_count) || result_valid !== 1'b0) begin
                n_fail++; $display("FAIL b2b_count f%0d: got cnt=%0d v=%b want %0d 0", f, frame_count, result_valid, exp_count); end
            n_cmp++; if (frame_count_w !== 2'(exp_count)) begin
                n_fail++; $display("FAIL b2b_wrap f%0d: got %0d want %0d", f, frame_count_w, exp_count % 4); end
            n_cmp++; if ({score_ready_w, result_valid_w, result_class_w, frame_err_w, cmp_final_w} !==
                         {score_ready, result_valid, result_class, frame_err, cmp_final}) begin
                n_fail++; $display("FAIL b2b_lockstep f%0d: narrow instance diverged", f); end
        end
        result_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_hold();
        test_ties();
        test_early_last();
        test_no_last();
        test_reset_in_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
